// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer slice.
//   lsu_state_t : sequencer FSM states
//   F3_*        : funct3 access size/sign encodings
//   lsu_ctx_t   : per-access context kept while the bus transaction is in flight
package lsu_pkg;

    localparam int unsigned BE_WIDTH = 4;
    localparam int unsigned WORD_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lsu_ctx_t;

endpackage

// File: rtl/lsu_sequencer_if.sv
// Handshaked data-memory bus between the load/store sequencer and memory.
//   master : sequencer side (drives request fields, receives gnt/rvalid/rdata)
//   slave  : memory side
interface lsu_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_be_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for a 32-bit data bus.
//   Request side: funct3/offset/wdata -> byte enables, replicated store data,
//                 misalign and illegal-funct3 flags.
//   Load side   : latched funct3/offset + bus read data -> extended load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          offset,
    input  logic [WORD_W-1:0]   wdata,
    output logic [BE_WIDTH-1:0] be_c,
    output logic [WORD_W-1:0]   wdata_c,
    output logic                misalign_c,
    output logic                illegal_f3_c,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_offset,
    input  logic [WORD_W-1:0]   rdata,
    output logic [WORD_W-1:0]   ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request-side lane placement and legality.
    always_comb begin
        be_c         = '0;
        wdata_c      = '0;
        misalign_c   = 1'b0;
        illegal_f3_c = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be_c    = 4'b0001 << offset;
                wdata_c = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be_c       = 4'b0011 << {offset[1], 1'b0};
                wdata_c    = {2{wdata[15:0]}};
                misalign_c = offset[0];
            end
            F3_W: begin
                be_c       = 4'b1111;
                wdata_c    = wdata;
                misalign_c = |offset;
            end
            default: illegal_f3_c = 1'b1;
        endcase
    end

    // Load-side lane select and sign/zero extension.
    always_comb begin
        ld_byte   = 8'(rdata >> {ld_offset, 3'b000});
        ld_half   = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        ld_data_c = rdata;
        case (ld_funct3)
            F3_B:    ld_data_c = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_c = {24'd0, ld_byte};
            F3_H:    ld_data_c = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_c = {16'd0, ld_half};
            default: ld_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: one bus transaction per memrd/memw request,
// stalls the core until the access completes, flags illegal accesses and
// aborts transactions that exceed TIMEOUT_CYCLES (0 disables the timeout).
//   clk_i/rst_i          : clock, synchronous active-high reset
//   memrd_i/memw_i       : load/store request from decode
//   funct3_i/addr_i/wdata_i : access size/sign, effective address, store data
//   stall_o              : combinational PC/regfile hold
//   rdata_o/done_o       : extended load data, retire pulse
//   err_o/timeout_o      : illegal-access pulse, bus-timeout pulse
//   bus                  : data-memory bus (master side)
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memrd_i,
    input  logic              memw_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              timeout_o,
    lsu_sequencer_if.master   bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t          state_q, state_d;
    lsu_ctx_t            ctx_q;
    logic [CNT_W-1:0]    tmo_cnt_q;

    logic [BE_WIDTH-1:0] be_c;
    logic [WORD_W-1:0]   wdata_c;
    logic [WORD_W-1:0]   ld_data_c;
    logic                misalign_c, illegal_f3_c;

    logic access_c, illegal_c, accept_c, tmo_hit_c, complete_c, abort_c;
    logic req_d, done_d, err_d, timeout_d;

    lsu_align u_align (
        .funct3       (funct3_i),
        .offset       (addr_i[1:0]),
        .wdata        (wdata_i),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .misalign_c   (misalign_c),
        .illegal_f3_c (illegal_f3_c),
        .ld_funct3    (ctx_q.funct3),
        .ld_offset    (ctx_q.offset),
        .rdata        (bus.bus_rdata_i),
        .ld_data_c    (ld_data_c)
    );

    // Request qualification and in-flight completion/abort conditions.
    always_comb begin
        access_c   = memrd_i | memw_i;
        illegal_c  = (memrd_i & memw_i) | illegal_f3_c | misalign_c;
        accept_c   = (state_q == ST_IDLE) & access_c & ~illegal_c;
        tmo_hit_c  = (TIMEOUT_CYCLES != 0) && ((32'(tmo_cnt_q) + 32'd1) == TIMEOUT_CYCLES);
        complete_c = ((state_q == ST_REQ) & bus.bus_gnt_i & bus.bus_rvalid_i) |
                     ((state_q == ST_WAIT) & bus.bus_rvalid_i);
        abort_c    = ((state_q == ST_REQ) | (state_q == ST_WAIT)) & tmo_hit_c & ~complete_c;
    end

    // State register and timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    // Next-state logic; a response arriving in the timeout cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_REQ;
            ST_REQ: begin
                if (complete_c || abort_c) state_d = ST_DONE;
                else if (bus.bus_gnt_i)    state_d = ST_WAIT;
            end
            ST_WAIT: if (complete_c || abort_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: stall is combinational, the rest feed output flops.
    always_comb begin
        stall_o   = ~rst_i & (accept_c | (state_q == ST_REQ) | (state_q == ST_WAIT));
        req_d     = (state_d == ST_REQ);
        done_d    = complete_c;
        timeout_d = abort_c;
        err_d     = (state_q == ST_IDLE) & access_c & illegal_c;
    end

    // Registered outputs and latched request fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_be_o    <= '0;
            bus.bus_wdata_o <= '0;
            rdata_o         <= '0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            timeout_o       <= 1'b0;
            ctx_q           <= '0;
        end else begin
            bus.bus_req_o <= req_d;
            done_o        <= done_d;
            err_o         <= err_d;
            timeout_o     <= timeout_d;
            if (accept_c) begin
                bus.bus_we_o    <= memw_i;
                bus.bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                bus.bus_be_o    <= be_c;
                bus.bus_wdata_o <= DATA_W'(wdata_c);
                ctx_q           <= '{we: memw_i, funct3: funct3_i, offset: addr_i[1:0]};
            end
            // Stores never disturb the last load result.
            if (complete_c && !ctx_q.we) begin
                rdata_o <= DATA_W'(ld_data_c);
            end else if (abort_c && !ctx_q.we) begin
                rdata_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          memrd, memw;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall, done, err, timeout;
    logic [DW-1:0] rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    lsu_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    lsu_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .memrd_i   (memrd),
        .memw_i    (memw),
        .funct3_i  (funct3),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .stall_o   (stall),
        .rdata_o   (rdata),
        .done_o    (done),
        .err_o     (err),
        .timeout_o (timeout),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: access width in bytes from funct3.
    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] a);
        if (rd && wr) return 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz  = size_of(f3);
        int unsigned off = a % 4;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        int unsigned sz  = size_of(f3);
        int unsigned off = a % 4;
        logic [31:0] v, mask;
        v    = d >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Idle cycle with a stray bus response that must be ignored.
    task automatic idle_gap();
        memrd = 1'b0;
        memw  = 1'b0;
        bus.bus_rvalid_i = 1'($urandom % 2);
        bus.bus_gnt_i    = 1'($urandom % 2);
        bus.bus_rdata_i  = $urandom;
        @(negedge clk);
        check("gap_done", done, 0);
        check("gap_err", err, 0);
        check("gap_req", bus.bus_req_o, 0);
        check("gap_stall", stall, 0);
        check("gap_rdata", rdata, exp_rdata);
        bus.bus_rvalid_i = 1'b0;
        bus.bus_gnt_i    = 1'b0;
    endtask

    // One access; grant gd cycles into REQ, response rvd cycles after grant.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd_data, input int gd, input int rvd);
        bit legal   = is_legal(rd, wr, f3, a);
        int done_ix = gd + rvd + 1;
        memrd  = rd;
        memw   = wr;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        bus.bus_rdata_i = rd_data;
        #1 check("stall_accept", stall, 32'(legal));
        @(negedge clk);
        if (!legal) begin
            check("err_pulse", err, 1);
            check("err_req", bus.bus_req_o, 0);
            check("err_stall", stall, 0);
            check("err_done", done, 0);
        end else begin
            for (int i = 0; i <= done_ix; i++) begin
                check("req", bus.bus_req_o, 32'(i <= gd));
                check("stall", stall, 32'(i < done_ix));
                check("done", done, 32'(i == done_ix));
                if (i == 0) begin
                    check("addr", bus.bus_addr_o, a & ~32'd3);
                    check("be", 32'(bus.bus_be_o), 32'(exp_be(f3, a)));
                    check("we", bus.bus_we_o, 32'(wr));
                    if (wr) check("wdata", bus.bus_wdata_o, exp_wdata(f3, wd));
                end
                if (i == done_ix) begin
                    if (rd) exp_rdata = exp_load(f3, a, rd_data);
                    check("rdata", rdata, exp_rdata);
                end
                bus.bus_gnt_i    = (i == gd);
                bus.bus_rvalid_i = (i == gd + rvd);
                if (i < done_ix) @(negedge clk);
            end
        end
        idle_gap();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; memrd = 1'b0; memw = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
        bus.bus_gnt_i = 1'b0; bus.bus_rvalid_i = 1'b0; bus.bus_rdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_req", bus.bus_req_o, 0);
        check("rst_be", 32'(bus.bus_be_o), 0);
        check("rst_addr", bus.bus_addr_o, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 0, 1);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 1, 0);
        run_access(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0, 1);
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
        run_access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);
        run_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);

        // Randomized accesses.
        for (int n = 0; n < 80; n++) begin
            int unsigned kind = $urandom % 4;
            logic rd_b = (kind == 0) || (kind == 1) || (kind == 3);
            logic wr_b = (kind == 2) || (kind == 3);
            run_access(rd_b, wr_b, 3'($urandom % 8), $urandom, $urandom, $urandom,
                       int'($urandom % 4), int'($urandom % 4));
        end

        // Load with grant never given: abort after TMO request cycles.
        memrd = 1'b1; memw = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        for (int i = 0; i <= int'(TMO); i++) begin
            check("tmo_req", bus.bus_req_o, 32'(i < int'(TMO)));
            check("tmo_pulse", timeout, 32'(i == int'(TMO)));
            check("tmo_stall", stall, 32'(i < int'(TMO)));
            check("tmo_done", done, 0);
            if (i < int'(TMO)) @(negedge clk);
        end
        exp_rdata = 32'd0;
        check("tmo_rdata", rdata, exp_rdata);
        idle_gap();
        check("tmo_clear", timeout, 0);

        // Reset while waiting for the response.
        run_access(1, 0, 3'b010, 32'h40, 32'h0, 32'h1357_9BDF, 0, 0);
        memrd = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(negedge clk);
        bus.bus_gnt_i = 1'b1;
        @(negedge clk);
        bus.bus_gnt_i = 1'b0;
        rst = 1'b1;
        #1 check("rst_mid_stall", stall, 0);
        @(negedge clk);
        check("rst_mid_req", bus.bus_req_o, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_done", done, 0);
        rst = 1'b0; memrd = 1'b0;
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.bus_rvalid_i = 1'b0;
        exp_rdata = 32'd0;
        check("post_rst_done", done, 0);
        check("post_rst_rdata", rdata, exp_rdata);
        check("post_rst_req", bus.bus_req_o, 0);
        check("post_rst_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
